keypad_arbiter: RTL

Shares the single safe-lock FSM between two physical keypads (panel A and panel B), each presenting active-low 4-bit buttons where 4'b1111 means nothing is pressed. It grants one panel per session and debounces that panel's presses. Each accepted press is forwarded to the lock's `btn` input as a clean single-cycle code. Sessions end on inactivity, and contested sessions alternate between panels round-robin.

---
 rtl/keypad_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/keypad_arbiter.sv
// Arbitrates two active-low keypads onto one lock input: one panel per session,
// debounced single-cycle press pulses, inactivity timeout and round-robin tie-breaking.
module keypad_arbiter #(
  parameter int unsigned DEBOUNCE = 1_000_000,
  parameter int unsigned TIMEOUT  = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_a,
  input  logic [3:0] btn_b,
  output logic [3:0] lock_btn,
  output logic       grant_a,
  output logic       grant_b,
  output logic       denied_a,
  output logic       denied_b
);

  localparam int unsigned SW = $clog2(DEBOUNCE + 1);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] StableLast = SW'(DEBOUNCE - 1);
  localparam logic [IW-1:0] IdleLast   = IW'(TIMEOUT - 1);
  localparam logic [3:0]    NoKey      = 4'b1111;

  typedef enum logic [1:0] {StIdle, StOwn, StPress, StRelease} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [3:0]    code_q, code_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          denied_a_q, denied_b_q;

  logic       req_a, req_b, pick;
  logic [3:0] obtn;

  assign req_a = (btn_a != NoKey);
  assign req_b = (btn_b != NoKey);
  // On a tie the panel that did not hold the previous session wins.
  assign pick  = (req_a && req_b) ? ~last_q : req_b;
  assign obtn  = owner_q ? btn_b : btn_a;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    code_d   = code_q;
    stable_d = stable_q;
    idle_d   = idle_q;
    case (state_q)
      StIdle: begin
        if (req_a || req_b) begin
          owner_d  = pick;
          last_d   = pick;
          // The winning press is only remembered here; it must still debounce in StOwn.
          code_d   = pick ? btn_b : btn_a;
          stable_d = '0;
          idle_d   = '0;
          state_d  = StOwn;
        end
      end
      StOwn: begin
        if (obtn == NoKey) begin
          stable_d = '0;
          idle_d   = idle_q + 1'b1;
          if (idle_q == IdleLast) state_d = StIdle;
        end else begin
          idle_d = '0;
          if (obtn != code_q) begin
            code_d   = obtn;
            stable_d = '0;
          end else if (stable_q == StableLast) begin
            state_d = StPress;
          end else begin
            stable_d = stable_q + 1'b1;
          end
        end
      end
      StPress: begin
        stable_d = '0;
        state_d  = StRelease;
      end
      StRelease: begin
        if (obtn != NoKey) begin
          stable_d = '0;
        end else if (stable_q == StableLast) begin
          stable_d = '0;
          code_d   = NoKey;
          state_d  = StOwn;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      code_q     <= NoKey;
      stable_q   <= '0;
      idle_q     <= '0;
      denied_a_q <= 1'b0;
      denied_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      code_q     <= code_d;
      stable_q   <= stable_d;
      idle_q     <= idle_d;
      denied_a_q <= grant_b && req_a;
      denied_b_q <= grant_a && req_b;
    end
  end

  assign lock_btn = (state_q == StPress) ? code_q : NoKey;
  assign grant_a  = (state_q != StIdle) && !owner_q;
  assign grant_b  = (state_q != StIdle) && owner_q;
  assign denied_a = denied_a_q;
  assign denied_b = denied_b_q;

endmodule
